// File: rtl/reg_file_wb_arbiter_pkg.sv
// Shared widths, payload types and helpers for the register file writeback arbiter.
package reg_file_wb_arbiter_pkg;

    localparam int unsigned NUM_REQ        = 3;
    localparam int unsigned NUM_REGS       = 16;
    localparam int unsigned SEL_W          = $clog2(NUM_REGS);
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned NUM_READ_PORTS = 3;
    localparam int unsigned PTR_W          = $clog2(NUM_REQ);

    typedef logic [SEL_W-1:0]  reg_sel_t;
    typedef logic [DATA_W-1:0] reg_data_t;
    typedef logic [PTR_W-1:0]  req_idx_t;

    // One writeback request as presented by a source.
    typedef struct packed {
        reg_sel_t  sel;
        reg_data_t data;
    } reg_file_write_req_t;

    // Register file write port as driven by the arbiter.
    typedef struct packed {
        logic      write_en;
        reg_sel_t  write_sel;
        reg_data_t write_data;
    } reg_file_write_port_t;

    // Requester index following idx, wrapping at NUM_REQ.
    function automatic req_idx_t next_req_idx(input req_idx_t idx);
        return (idx == req_idx_t'(NUM_REQ - 1)) ? '0 : idx + req_idx_t'(1);
    endfunction

endpackage

// File: rtl/reg_file_wb_arbiter_if.sv
// Writeback, reservation, hazard and register file write signals of the arbiter.
interface reg_file_wb_arbiter_if;
    import reg_file_wb_arbiter_pkg::*;

    logic      [NUM_REQ-1:0]        req_valid;
    reg_sel_t  [NUM_REQ-1:0]        req_sel;
    reg_data_t [NUM_REQ-1:0]        req_data;
    logic      [NUM_REQ-1:0]        req_ready;
    logic                           reserve_en;
    reg_sel_t                       reserve_sel;
    reg_sel_t  [NUM_READ_PORTS-1:0] read_sel;
    logic      [NUM_READ_PORTS-1:0] read_hazard;
    logic                           rf_write_en;
    reg_sel_t                       rf_write_sel;
    reg_data_t                      rf_write_data;
    logic                           err_reserve_busy;

    // Execute/decode side: presents writes, reservations and read selects.
    modport master (
        output req_valid, req_sel, req_data, reserve_en, reserve_sel, read_sel,
        input  req_ready, read_hazard, rf_write_en, rf_write_sel, rf_write_data,
               err_reserve_busy
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_sel, req_data, reserve_en, reserve_sel, read_sel,
        output req_ready, read_hazard, rf_write_en, rf_write_sel, rf_write_data,
               err_reserve_busy
    );

endinterface

// File: rtl/reg_file_wb_pick.sv
// One-hot pick of the first valid requester searching upward from a start index.
module reg_file_wb_pick #(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] start,
    output logic [N-1:0]     grant_c
);

    logic        found;
    int unsigned idx;

    // Walk the requesters circularly from start; the first valid one wins.
    always_comb begin
        grant_c = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = (32'(start) + off) % N;
            if (!found && valid[IDX_W'(idx)]) begin
                grant_c[IDX_W'(idx)] = 1'b1;
                found                = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_file_wb_arbiter.sv
// Register file writeback arbiter with busy scoreboard and read-hazard flags.
// Define REG_FILE_WB_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise the lowest requester index wins.
module reg_file_wb_arbiter
    import reg_file_wb_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    reg_file_wb_arbiter_if.slave bus
);

    logic [NUM_REQ-1:0]        valid_c;
    logic [NUM_REQ-1:0]        grant_c;
    req_idx_t                  start_c;
    logic                      any_grant_c;
    reg_file_write_req_t       win_c;
    reg_file_write_port_t      wp_q, wp_d;
    logic [NUM_REGS-1:0]       busy_q, busy_d;
    logic                      err_q, err_d;
    logic [NUM_READ_PORTS-1:0] hazard_c;

    // A request presented during reset is not granted; the source re-presents later.
    assign valid_c = bus.req_valid & {NUM_REQ{~rst}};

`ifdef REG_FILE_WB_ARB_ROUND_ROBIN_EN
    req_idx_t rr_ptr, rr_ptr_nxt;

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (rst) rr_ptr <= '0;
        else     rr_ptr <= rr_ptr_nxt;
    end

    // Move the pointer past the granted requester; hold when idle.
    always_comb begin
        rr_ptr_nxt = rr_ptr;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (grant_c[k]) rr_ptr_nxt = next_req_idx(req_idx_t'(k));
        end
    end

    assign start_c = rr_ptr;
`else
    assign start_c = '0;
`endif

    reg_file_wb_pick #(
        .N     (NUM_REQ),
        .IDX_W (PTR_W)
    ) u_pick (
        .valid   (valid_c),
        .start   (start_c),
        .grant_c (grant_c)
    );

    assign bus.req_ready = grant_c;
    assign any_grant_c   = |grant_c;

    // Select the granted requester's payload.
    always_comb begin
        win_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_c[i]) begin
                win_c.sel  = bus.req_sel[i];
                win_c.data = bus.req_data[i];
            end
        end
    end

    // Next write port, scoreboard and error flag; a reservation overrides a same-cycle clear.
    always_comb begin
        wp_d          = wp_q;
        busy_d        = busy_q;
        err_d         = err_q;
        wp_d.write_en = any_grant_c;
        if (any_grant_c) begin
            wp_d.write_sel     = win_c.sel;
            wp_d.write_data    = win_c.data;
            busy_d[win_c.sel]  = 1'b0;
        end
        if (bus.reserve_en) begin
            busy_d[bus.reserve_sel] = 1'b1;
            if (busy_q[bus.reserve_sel] &&
                !(any_grant_c && (win_c.sel == bus.reserve_sel))) begin
                err_d = 1'b1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q   <= '0;
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wp_q   <= wp_d;
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    // A read is stale if its register is pending or is being written out this cycle.
    always_comb begin
        hazard_c = '0;
        for (int unsigned j = 0; j < NUM_READ_PORTS; j++) begin
            hazard_c[j] = busy_q[bus.read_sel[j]] |
                          (wp_q.write_en & (wp_q.write_sel == bus.read_sel[j]));
        end
    end

    assign bus.read_hazard      = hazard_c;
    assign bus.rf_write_en      = wp_q.write_en;
    assign bus.rf_write_sel     = wp_q.write_sel;
    assign bus.rf_write_data    = wp_q.write_data;
    assign bus.err_reserve_busy = err_q;

endmodule

// File: tb/tb_reg_file_wb_arbiter.sv
// Bench for reg_file_wb_arbiter; arbitration expectations follow
// REG_FILE_WB_ARB_ROUND_ROBIN_EN when it is defined.
module tb_reg_file_wb_arbiter;
    import reg_file_wb_arbiter_pkg::*;

    logic clk;
    logic rst;

    reg_file_wb_arbiter_if bus();

    reg_file_wb_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total;
    int bad;

    reg_file_write_req_t exp_q[$];
    int                  m_rr;
    logic                m_en;
    reg_sel_t            m_sel;
    reg_data_t           m_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_idle();
        bus.req_valid   = '0;
        bus.req_sel     = '0;
        bus.req_data    = '0;
        bus.reserve_en  = 1'b0;
        bus.reserve_sel = '0;
        bus.read_sel    = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_rr   = 0;
        m_en   = 1'b0;
        m_sel  = '0;
        m_data = '0;
        exp_q.delete();
    endtask

    task automatic apply_reset();
        drive_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    // Expected grantee: first valid requester searching from start.
    function automatic int model_pick(input logic [NUM_REQ-1:0] v, input int start);
        for (int off = 0; off < NUM_REQ; off++) begin
            int idx;
            idx = (start + off) % NUM_REQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_advance_rr(input int k);
`ifdef REG_FILE_WB_ARB_ROUND_ROBIN_EN
        if (k >= 0) m_rr = (k + 1) % NUM_REQ;
`else
        if (k >= NUM_REQ) m_rr = 0;
`endif
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        tick();
        tick();
        total += 5;
        if (bus.rf_write_en !== 1'b0) begin bad++; $display("FAIL reset_en: got %0b want 0", bus.rf_write_en); end
        if (bus.rf_write_sel !== '0) begin bad++; $display("FAIL reset_sel: got %0d want 0", bus.rf_write_sel); end
        if (bus.rf_write_data !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", bus.rf_write_data); end
        if (bus.err_reserve_busy !== 1'b0) begin bad++; $display("FAIL reset_err: got %0b want 0", bus.err_reserve_busy); end
        if (bus.read_hazard !== '0) begin bad++; $display("FAIL reset_hazard: got %b want 000", bus.read_hazard); end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_single();
        reg_file_write_req_t e;
        apply_reset();
        bus.req_valid   = 3'b010;
        bus.req_sel[1]  = 4'd5;
        bus.req_data[1] = 32'hDEADBEEF;
        @(negedge clk);
        total++;
        if (bus.req_ready !== 3'b010) begin bad++; $display("FAIL single_ready: got %b want 010", bus.req_ready); end
        exp_q.push_back('{sel: 4'd5, data: 32'hDEADBEEF});
        model_advance_rr(1);
        tick();
        drive_idle();
        total += 3;
        if (exp_q.size() == 0) begin
            bad++; $display("FAIL single_sb: got empty queue want one entry");
        end else begin
            e = exp_q.pop_front();
            if (bus.rf_write_en !== 1'b1) begin bad++; $display("FAIL single_en: got %0b want 1", bus.rf_write_en); end
            if (bus.rf_write_sel !== e.sel) begin bad++; $display("FAIL single_sel: got %0d want %0d", bus.rf_write_sel, e.sel); end
            if (bus.rf_write_data !== e.data) begin bad++; $display("FAIL single_data: got %h want %h", bus.rf_write_data, e.data); end
        end
        tick();
        total += 3;
        if (bus.rf_write_en !== 1'b0) begin bad++; $display("FAIL hold_en: got %0b want 0", bus.rf_write_en); end
        if (bus.rf_write_sel !== 4'd5) begin bad++; $display("FAIL hold_sel: got %0d want 5", bus.rf_write_sel); end
        if (bus.rf_write_data !== 32'hDEADBEEF) begin bad++; $display("FAIL hold_data: got %h want deadbeef", bus.rf_write_data); end
    endtask

    task automatic test_arbitration();
        reg_file_write_req_t   e;
        int                    k;
        logic [NUM_REQ-1:0]    er;
        apply_reset();
        for (int c = 0; c < 3; c++) begin
            bus.req_valid = '1;
            for (int i = 0; i < NUM_REQ; i++) begin
                bus.req_sel[i]  = SEL_W'(i + 1);
                bus.req_data[i] = 32'hA000_0000 | 32'(c << 8) | 32'(i);
            end
            @(negedge clk);
            k  = model_pick('1, m_rr);
            er = '0;
            er[k] = 1'b1;
            total++;
            if (bus.req_ready !== er) begin bad++; $display("FAIL arb_ready_%0d: got %b want %b", c, bus.req_ready, er); end
            exp_q.push_back('{sel: bus.req_sel[k], data: bus.req_data[k]});
            model_advance_rr(k);
            tick();
            e = exp_q.pop_front();
            total += 2;
            if (bus.rf_write_sel !== e.sel) begin bad++; $display("FAIL arb_sel_%0d: got %0d want %0d", c, bus.rf_write_sel, e.sel); end
            if (bus.rf_write_data !== e.data) begin bad++; $display("FAIL arb_data_%0d: got %h want %h", c, bus.rf_write_data, e.data); end
        end
        drive_idle();
`ifdef REG_FILE_WB_ARB_ROUND_ROBIN_EN
        total++;
        if (dut.rr_ptr !== PTR_W'(m_rr)) begin bad++; $display("FAIL arb_rr_ptr: got %0d want %0d", dut.rr_ptr, m_rr); end
`endif
    endtask

    task automatic test_hazard();
        reg_file_write_req_t e;
        drive_idle();
        tick();
        bus.reserve_en  = 1'b1;
        bus.reserve_sel = 4'd7;
        bus.read_sel[0] = 4'd7;
        bus.read_sel[1] = 4'd8;
        @(negedge clk);
        total++;
        if (bus.read_hazard !== 3'b000) begin bad++; $display("FAIL haz_before: got %b want 000", bus.read_hazard); end
        tick();
        bus.reserve_en = 1'b0;
        @(negedge clk);
        total++;
        if (bus.read_hazard !== 3'b001) begin bad++; $display("FAIL haz_busy: got %b want 001", bus.read_hazard); end
        tick();
        bus.req_valid   = 3'b100;
        bus.req_sel[2]  = 4'd7;
        bus.req_data[2] = 32'h7777_0007;
        @(negedge clk);
        total += 2;
        if (bus.req_ready !== 3'b100) begin bad++; $display("FAIL haz_ready: got %b want 100", bus.req_ready); end
        if (bus.read_hazard !== 3'b001) begin bad++; $display("FAIL haz_grant: got %b want 001", bus.read_hazard); end
        exp_q.push_back('{sel: 4'd7, data: 32'h7777_0007});
        model_advance_rr(2);
        tick();
        bus.req_valid = '0;
        e = exp_q.pop_front();
        total += 2;
        if (bus.rf_write_en !== 1'b1) begin bad++; $display("FAIL haz_wr_en: got %0b want 1", bus.rf_write_en); end
        if (bus.rf_write_data !== e.data) begin bad++; $display("FAIL haz_wr_data: got %h want %h", bus.rf_write_data, e.data); end
        @(negedge clk);
        total++;
        if (bus.read_hazard !== 3'b001) begin bad++; $display("FAIL haz_outreg: got %b want 001", bus.read_hazard); end
        tick();
        @(negedge clk);
        total++;
        if (bus.read_hazard !== 3'b000) begin bad++; $display("FAIL haz_cleared: got %b want 000", bus.read_hazard); end
        tick();
    endtask

    task automatic test_same_cycle();
        reg_file_write_req_t e;
        int                  k;
        drive_idle();
        bus.read_sel[0] = 4'd3;
        bus.reserve_en  = 1'b1;
        bus.reserve_sel = 4'd3;
        tick();
        bus.req_valid   = 3'b001;
        bus.req_sel[0]  = 4'd3;
        bus.req_data[0] = 32'h3333_0033;
        @(negedge clk);
        k = model_pick(3'b001, m_rr);
        total++;
        if (bus.req_ready !== 3'b001 || k != 0) begin bad++; $display("FAIL same_ready: got %b want 001", bus.req_ready); end
        exp_q.push_back('{sel: 4'd3, data: 32'h3333_0033});
        model_advance_rr(k);
        tick();
        bus.req_valid  = '0;
        bus.reserve_en = 1'b0;
        e = exp_q.pop_front();
        total += 2;
        if (bus.rf_write_sel !== e.sel) begin bad++; $display("FAIL same_sel: got %0d want %0d", bus.rf_write_sel, e.sel); end
        if (bus.err_reserve_busy !== 1'b0) begin bad++; $display("FAIL same_err: got %0b want 0", bus.err_reserve_busy); end
        tick();
        @(negedge clk);
        total += 2;
        if (bus.rf_write_en !== 1'b0) begin bad++; $display("FAIL same_idle_en: got %0b want 0", bus.rf_write_en); end
        if (bus.read_hazard[0] !== 1'b1) begin bad++; $display("FAIL same_busy: got %0b want 1", bus.read_hazard[0]); end
        bus.reserve_en = 1'b1;
        tick();
        bus.reserve_en = 1'b0;
        total++;
        if (bus.err_reserve_busy !== 1'b1) begin bad++; $display("FAIL err_set: got %0b want 1", bus.err_reserve_busy); end
        tick();
        tick();
        total++;
        if (bus.err_reserve_busy !== 1'b1) begin bad++; $display("FAIL err_sticky: got %0b want 1", bus.err_reserve_busy); end
    endtask

    task automatic test_reset_mid();
        drive_idle();
        bus.read_sel[0] = 4'd9;
        bus.read_sel[1] = 4'd3;
        bus.reserve_en  = 1'b1;
        bus.reserve_sel = 4'd9;
        tick();
        bus.reserve_en  = 1'b0;
        bus.req_valid   = 3'b001;
        bus.req_sel[0]  = 4'd4;
        bus.req_data[0] = 32'h4444_0044;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (bus.read_hazard !== 3'b011) begin bad++; $display("FAIL rstmid_pre_haz: got %b want 011", bus.read_hazard); end
        tick();
        rst = 1'b0;
        bus.req_valid = '0;
        model_reset();
        total += 4;
        if (bus.rf_write_en !== 1'b0) begin bad++; $display("FAIL rstmid_en: got %0b want 0", bus.rf_write_en); end
        if (bus.rf_write_sel !== '0) begin bad++; $display("FAIL rstmid_sel: got %0d want 0", bus.rf_write_sel); end
        if (bus.rf_write_data !== '0) begin bad++; $display("FAIL rstmid_data: got %h want 0", bus.rf_write_data); end
        if (bus.err_reserve_busy !== 1'b0) begin bad++; $display("FAIL rstmid_err: got %0b want 0", bus.err_reserve_busy); end
        @(negedge clk);
        total++;
        if (bus.read_hazard !== 3'b000) begin bad++; $display("FAIL rstmid_haz: got %b want 000", bus.read_hazard); end
        tick();
    endtask

    task automatic test_back_to_back();
        reg_file_write_req_t                e;
        int                                 k;
        logic [NUM_REQ-1:0]                 er;
        logic [NUM_READ_PORTS-1:0]          eh;
        drive_idle();
        for (int c = 0; c < 24; c++) begin
            bus.req_valid = NUM_REQ'($urandom_range(0, 7));
            for (int i = 0; i < NUM_REQ; i++) begin
                bus.req_sel[i]  = SEL_W'($urandom_range(0, NUM_REGS - 1));
                bus.req_data[i] = $urandom();
            end
            for (int j = 0; j < NUM_READ_PORTS; j++) begin
                bus.read_sel[j] = SEL_W'($urandom_range(0, NUM_REGS - 1));
            end
            if (c % 4 == 0) bus.read_sel[0] = m_sel;
            @(negedge clk);
            k  = model_pick(bus.req_valid, m_rr);
            er = '0;
            if (k >= 0) er[k] = 1'b1;
            for (int j = 0; j < NUM_READ_PORTS; j++) begin
                eh[j] = m_en && (m_sel == bus.read_sel[j]);
            end
            total += 2;
            if (bus.req_ready !== er) begin bad++; $display("FAIL b2b_ready_%0d: got %b want %b", c, bus.req_ready, er); end
            if (bus.read_hazard !== eh) begin bad++; $display("FAIL b2b_haz_%0d: got %b want %b", c, bus.read_hazard, eh); end
            if (k >= 0) exp_q.push_back('{sel: bus.req_sel[k], data: bus.req_data[k]});
            model_advance_rr(k);
            tick();
            if (exp_q.size() > 0) begin
                e      = exp_q.pop_front();
                m_en   = 1'b1;
                m_sel  = e.sel;
                m_data = e.data;
            end else begin
                m_en = 1'b0;
            end
            total += 3;
            if (bus.rf_write_en !== m_en) begin bad++; $display("FAIL b2b_en_%0d: got %0b want %0b", c, bus.rf_write_en, m_en); end
            if (bus.rf_write_sel !== m_sel) begin bad++; $display("FAIL b2b_sel_%0d: got %0d want %0d", c, bus.rf_write_sel, m_sel); end
            if (bus.rf_write_data !== m_data) begin bad++; $display("FAIL b2b_data_%0d: got %h want %h", c, bus.rf_write_data, m_data); end
        end
        drive_idle();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        drive_idle();
        model_reset();
        test_reset();
        test_single();
        test_arbitration();
        test_hazard();
        test_same_cycle();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
